// File: rtl/nonce_scheduler_if.sv
// Handshake/bus bundle between the nonce scheduler and its environment
// (key source, MD5 hash core, suffix extractor).
interface nonce_scheduler_if #(
    parameter int KEY_BYTES     = 8,
    parameter int SUFFIX_DIGITS = 8
);
    localparam int BLOCK_HEADER_WIDTH = 8 * (KEY_BYTES + SUFFIX_DIGITS);
    localparam int KLW                = $clog2(KEY_BYTES + 1);

    logic                          key_valid;
    logic [8*KEY_BYTES-1:0]        key_data;
    logic [KLW-1:0]                key_len;
    logic                          header_valid;
    logic                          header_ready;
    logic [BLOCK_HEADER_WIDTH-1:0] header_data;
    logic                          digest_valid;
    logic [127:0]                  digest_data;
    logic                          hit_valid;
    logic [BLOCK_HEADER_WIDTH-1:0] hit_header;
    logic                          busy;
    logic                          overflow;

    // Scheduler side
    modport master (
        input  key_valid, key_data, key_len, header_ready, digest_valid, digest_data,
        output header_valid, header_data, hit_valid, hit_header, busy, overflow
    );

    // Environment side (key source, hash core, extractor)
    modport slave (
        output key_valid, key_data, key_len, header_ready, digest_valid, digest_data,
        input  header_valid, header_data, hit_valid, hit_header, busy, overflow
    );
endinterface

// File: rtl/nonce_scheduler.sv
// Search sequencer for the MD5 advent-coin miner: issues key+decimal-suffix
// headers in ascending order, tracks them in an in-order in-flight queue and
// reports the first header whose digest has the required leading zeros.
module nonce_scheduler #(
    parameter int KEY_BYTES     = 8,
    parameter int SUFFIX_DIGITS = 8,
    parameter int MAX_INFLIGHT  = 64,
    parameter int ZERO_NIBBLES  = 5
) (
    input  logic                clk,
    input  logic                reset,
    nonce_scheduler_if.master   bus
);
    localparam int BLOCK_HEADER_WIDTH = 8 * (KEY_BYTES + SUFFIX_DIGITS);
    localparam int KLW = $clog2(KEY_BYTES + 1);
    localparam int DW  = $clog2(SUFFIX_DIGITS + 1);
    localparam int AW  = $clog2(MAX_INFLIGHT);
    localparam int BIW = $clog2(BLOCK_HEADER_WIDTH);
    localparam int ZW  = 4 * ZERO_NIBBLES;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                         r_state, w_state_nxt;
    logic [8*KEY_BYTES-1:0]         r_key;
    logic [KLW-1:0]                 r_key_len;
    logic [SUFFIX_DIGITS-1:0][3:0]  r_bcd;
    logic [DW-1:0]                  r_ndig;
    logic [BLOCK_HEADER_WIDTH-1:0]  r_q [MAX_INFLIGHT];
    logic [AW-1:0]                  r_wp, r_rp;
    logic [AW:0]                    r_cnt;
    logic                           r_exhausted;
    logic                           r_hit_seen;
    logic                           r_hit_valid;
    logic [BLOCK_HEADER_WIDTH-1:0]  r_hit_header;

    logic                           w_start, w_full, w_pop, w_hv, w_push;
    logic                           w_zero, w_hit, w_last, w_all9, w_carry;
    logic [AW:0]                    w_cnt_nxt;
    logic [SUFFIX_DIGITS-1:0][3:0]  w_bcd_inc;
    logic [BLOCK_HEADER_WIDTH-1:0]  w_hdr;
    logic [BIW-1:0]                 w_pos;

    assign w_start   = bus.key_valid && (r_state == S_IDLE || r_state == S_DONE);
    assign w_full    = (r_cnt == (AW+1)'(MAX_INFLIGHT));
    assign w_pop     = bus.digest_valid && (r_cnt != '0) && (r_state != S_IDLE);
    // A same-cycle pop frees a slot, so a full queue can still issue.
    assign w_hv      = (r_state == S_ISSUE) && (!w_full || w_pop);
    assign w_push    = w_hv && bus.header_ready;
    assign w_zero    = (bus.digest_data[127 -: ZW] == '0);
    assign w_hit     = w_pop && w_zero && !r_hit_seen;
    assign w_cnt_nxt = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_last    = w_all9 && (r_ndig == DW'(SUFFIX_DIGITS));

    // BCD increment of the suffix; all-9 in the used digits grows the digit count.
    always_comb begin
        w_bcd_inc = r_bcd;
        w_all9    = 1'b1;
        w_carry   = 1'b1;
        for (int i = 0; i < SUFFIX_DIGITS; i++) begin
            if (w_carry) begin
                if (r_bcd[i] == 4'd9) begin
                    w_bcd_inc[i] = 4'd0;
                end else begin
                    w_bcd_inc[i] = r_bcd[i] + 4'd1;
                    w_carry      = 1'b0;
                end
            end
            if (i < int'(r_ndig) && r_bcd[i] != 4'd9) w_all9 = 1'b0;
        end
    end

    // Header assembly: ASCII suffix in the low bytes, reversed key above it.
    always_comb begin
        w_hdr = '0;
        w_pos = '0;
        for (int i = 0; i < SUFFIX_DIGITS; i++)
            if (i < int'(r_ndig)) w_hdr[8*i +: 8] = {4'h3, r_bcd[i]};
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (k < int'(r_key_len)) begin
                w_pos = BIW'(8 * (int'(r_ndig) + int'(r_key_len) - 1 - k));
                w_hdr[w_pos +: 8] = r_key[8*k +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: a hit or the final suffix stops issuing; drain ends on an empty queue.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (bus.key_valid) w_state_nxt = S_ISSUE;
            S_ISSUE:        if (w_hit || (w_push && w_last)) w_state_nxt = S_DRAIN;
            S_DRAIN:        if (w_cnt_nxt == '0) w_state_nxt = S_DONE;
            default:        w_state_nxt = S_IDLE;
        endcase
    end

    // Queue storage; pointers live with the control state below.
    always_ff @(posedge clk) begin
        if (w_push) r_q[r_wp] <= w_hdr;
    end

    // Suffix counter, queue pointers, hit capture and search bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_key        <= '0;
            r_key_len    <= '0;
            r_bcd        <= '0;
            r_ndig       <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_exhausted  <= 1'b0;
            r_hit_seen   <= 1'b0;
            r_hit_valid  <= 1'b0;
            r_hit_header <= '0;
        end else begin
            r_hit_valid <= w_hit;
            if (w_hit) begin
                r_hit_header <= r_q[r_rp];
                r_hit_seen   <= 1'b1;
            end
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_pop)  r_rp <= r_rp + AW'(1);
            r_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_bcd <= w_bcd_inc;
                if (w_all9 && !w_last) r_ndig <= r_ndig + DW'(1);
                if (w_last) r_exhausted <= 1'b1;
            end
            if (w_start) begin
                r_key       <= bus.key_data;
                r_key_len   <= bus.key_len;
                r_bcd       <= '0;
                r_bcd[0]    <= 4'd1;
                r_ndig      <= DW'(1);
                r_wp        <= '0;
                r_rp        <= '0;
                r_cnt       <= '0;
                r_exhausted <= 1'b0;
                r_hit_seen  <= 1'b0;
            end
        end
    end

    assign bus.header_valid = w_hv;
    assign bus.header_data  = w_hv ? w_hdr : '0;
    assign bus.hit_valid    = r_hit_valid;
    assign bus.hit_header   = r_hit_header;
    assign bus.busy         = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bus.overflow     = (r_state == S_DONE) && r_exhausted && !r_hit_seen;
endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a string/integer reference model.
module tb_nonce_scheduler;
    localparam int KB = 8, SD = 2, MI = 64, ZN = 5;
    localparam int HW = 8 * (KB + SD);
    localparam int MAXS = 99;
    localparam int P_IDLE = 0, P_ISSUE = 1, P_DRAIN = 2, P_DONE = 3;
    localparam logic [127:0] HIT_DIG  = 128'h0000_08ff_ffff_ffff_ffff_ffff_ffff_ffff;
    localparam logic [127:0] NEAR_DIG = 128'h0000_1000_0000_0000_0000_0000_0000_0000;

    logic clk, reset;
    nonce_scheduler_if #(.KEY_BYTES(KB), .SUFFIX_DIGITS(SD)) bus();

    nonce_scheduler #(.KEY_BYTES(KB), .SUFFIX_DIGITS(SD), .MAX_INFLIGHT(MI), .ZERO_NIBBLES(ZN)) dut (
        .clk(clk), .reset(reset), .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int n_hs = 0, n_hitp = 0;
    bit chk_on = 0;

    // reference model state
    int          m_phase = P_IDLE;
    int          m_q[$];
    int          m_next = 1;
    bit          m_exh = 0, m_hs = 0, m_hitv = 0;
    logic [HW-1:0] m_hith = '0;
    string       m_key = "";
    string       drv_key = "";
    int          hit_a = 0, hit_b = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] hdr_of(input string key, input int s);
        string msg;
        logic [HW-1:0] h;
        h = '0;
        msg = {key, $sformatf("%0d", s)};
        for (int i = 0; i < msg.len(); i++) h[8*i +: 8] = msg[msg.len()-1-i];
        return h;
    endfunction

    function automatic bit is_hit(input int s);
        return (hit_a != 0 && s == hit_a) || (hit_b != 0 && s == hit_b);
    endfunction

    // Per-cycle check of every output against the model, then advance the model.
    task automatic model_cycle();
        bit e_hv, pop, push, hv_n;
        int ph, s;
        e_hv = (m_phase == P_ISSUE) &&
               (m_q.size() < MI || (bus.digest_valid && m_q.size() > 0));
        if (chk_on) begin
            chk("header_valid", {127'b0, bus.header_valid}, {127'b0, e_hv});
            if (e_hv) chk("header_data", 128'(bus.header_data), 128'(hdr_of(m_key, m_next)));
            chk("busy", {127'b0, bus.busy}, {127'b0, (m_phase == P_ISSUE || m_phase == P_DRAIN)});
            chk("overflow", {127'b0, bus.overflow}, {127'b0, (m_phase == P_DONE && m_exh && !m_hs)});
            chk("hit_valid", {127'b0, bus.hit_valid}, {127'b0, m_hitv});
            chk("hit_header", 128'(bus.hit_header), 128'(m_hith));
            if (bus.header_valid && bus.header_ready) n_hs++;
            if (bus.hit_valid) n_hitp++;
        end
        if (reset) begin
            m_phase = P_IDLE; m_q.delete(); m_next = 1;
            m_exh = 0; m_hs = 0; m_hitv = 0; m_hith = '0;
        end else begin
            ph   = m_phase;
            hv_n = 0;
            pop  = bus.digest_valid && m_q.size() > 0 && ph != P_IDLE;
            push = e_hv && bus.header_ready;
            if (pop) begin
                s = m_q.pop_front();
                if (bus.digest_data[127 -: 4*ZN] == '0 && !m_hs) begin
                    hv_n = 1; m_hith = hdr_of(m_key, s); m_hs = 1;
                    if (ph == P_ISSUE) m_phase = P_DRAIN;
                end
            end
            if (push) begin
                m_q.push_back(m_next);
                if (m_next == MAXS) begin m_exh = 1; m_phase = P_DRAIN; end
                m_next++;
            end
            if (ph == P_DRAIN && m_q.size() == 0) m_phase = P_DONE;
            if ((ph == P_IDLE || ph == P_DONE) && bus.key_valid) begin
                m_phase = P_ISSUE; m_key = drv_key; m_next = 1; m_exh = 0; m_hs = 0;
            end
            m_hitv = hv_n;
        end
    endtask

    // One clock: drive inputs, compare at negedge, return 1 ns after posedge.
    task automatic step(input bit hr, input bit dv);
        bus.header_ready = hr;
        bus.digest_valid = dv;
        if (m_q.size() == 0)     bus.digest_data = HIT_DIG;
        else if (is_hit(m_q[0])) bus.digest_data = HIT_DIG;
        else                     bus.digest_data = NEAR_DIG;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        bus.key_valid    = 1'b0;
        bus.digest_valid = 1'b0;
    endtask

    task automatic load_key(input string k);
        bus.key_data = '0;
        for (int i = 0; i < k.len(); i++) bus.key_data[8*i +: 8] = k[i];
        bus.key_len   = 4'(k.len());
        bus.key_valid = 1'b1;
        drv_key       = k;
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while (m_phase != P_DONE && n < budget) begin
            step(1, 1);
            n++;
        end
        chk("done_within_budget", {127'b0, (n < budget)}, 128'd1);
        chk("busy_after_drain", {127'b0, bus.busy}, 128'd0);
    endtask

    initial begin
        int hs0, hp0, n;
        reset = 1'b1;
        bus.key_valid = 0; bus.key_data = '0; bus.key_len = '0;
        bus.header_ready = 0; bus.digest_valid = 0; bus.digest_data = '0;
        step(0, 0);
        step(0, 0);
        reset  = 1'b0;
        chk_on = 1;
        chk("rst_header_valid", {127'b0, bus.header_valid}, 128'd0);
        chk("rst_hit_valid", {127'b0, bus.hit_valid}, 128'd0);
        chk("rst_busy", {127'b0, bus.busy}, 128'd0);
        chk("rst_overflow", {127'b0, bus.overflow}, 128'd0);
        chk("rst_hit_header", 128'(bus.hit_header), 128'd0);
        chk("rst_header_data", 128'(bus.header_data), 128'd0);

        // Search with hit at suffix 12
        hit_a = 12; hit_b = 0; hp0 = n_hitp;
        load_key("abcdef");
        step(1, 0);
        chk("start_busy", {127'b0, bus.busy}, 128'd1);
        chk("start_valid", {127'b0, bus.header_valid}, 128'd1);
        chk("hdr_suffix1", 128'(bus.header_data), 128'h0000_0061_6263_6465_6631);
        step(1, 1);                                  // digest with empty queue: ignored
        for (int i = 0; i < 8; i++) step(1, 0);
        chk("hdr_suffix10", 128'(bus.header_data), 128'h0000_6162_6364_6566_3130);
        run_done(300);
        chk("hit12_header", 128'(bus.hit_header), 128'h0000_6162_6364_6566_3132);
        chk("hit12_pulses", n_hitp - hp0, 128'd1);
        chk("hit12_no_ovf", {127'b0, bus.overflow}, 128'd0);

        // Backpressure, plus a key pulse mid-search that must be ignored
        hit_a = 30;
        load_key("xyz");
        step(1, 0);
        for (int i = 0; i < 14; i++) step(1, 0);
        load_key("zzzz");
        for (int i = 0; i < 5; i++) step(0, 0);
        run_done(300);
        chk("xyz30_header", 128'(bus.hit_header), 128'h0000_0000_0078_797a_3330);

        // Queue full
        hit_a = 70; hs0 = n_hs;
        load_key("abcdef");
        for (int i = 0; i < 70; i++) step(1, 0);
        chk("full_accepted", n_hs - hs0, 128'd64);
        chk("full_valid_low", {127'b0, bus.header_valid}, 128'd0);
        step(1, 1);
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("full_one_more", n_hs - hs0, 128'd65);
        run_done(400);

        // Two zero-prefix digests among 10 outstanding
        hit_a = 3; hit_b = 5; hp0 = n_hitp;
        load_key("abcdef");
        for (int i = 0; i < 11; i++) step(1, 0);
        for (int i = 0; i < 12; i++) step(0, 1);
        chk("two_hits_pulses", n_hitp - hp0, 128'd1);
        chk("two_hits_header", 128'(bus.hit_header), 128'h0000_0061_6263_6465_6633);
        chk("two_hits_done", {127'b0, bus.busy}, 128'd0);

        // Suffix exhaustion -> overflow
        hit_a = 0; hit_b = 0; hp0 = n_hitp; hs0 = n_hs;
        load_key("k");
        step(1, 0);
        run_done(600);
        chk("ovf_set", {127'b0, bus.overflow}, 128'd1);
        chk("ovf_headers", n_hs - hs0, 128'd99);
        chk("ovf_no_hit", n_hitp - hp0, 128'd0);
        load_key("abcdef");
        step(0, 0);
        chk("ovf_cleared", {127'b0, bus.overflow}, 128'd0);
        chk("restart_busy", {127'b0, bus.busy}, 128'd1);

        // Reset at suffix 40 with 8 in flight
        for (int i = 0; i < 8; i++) step(1, 0);
        n = 0;
        while (m_next < 40 && n < 100) begin step(1, 1); n++; end
        chk("reach_suffix40", {127'b0, (n < 100)}, 128'd1);
        reset = 1'b1;
        step(0, 0);
        reset = 1'b0;
        chk("mid_rst_valid", {127'b0, bus.header_valid}, 128'd0);
        chk("mid_rst_hit_valid", {127'b0, bus.hit_valid}, 128'd0);
        chk("mid_rst_busy", {127'b0, bus.busy}, 128'd0);
        chk("mid_rst_overflow", {127'b0, bus.overflow}, 128'd0);
        chk("mid_rst_hit_header", 128'(bus.hit_header), 128'd0);
        chk("mid_rst_header_data", 128'(bus.header_data), 128'd0);
        hp0 = n_hitp;
        for (int i = 0; i < 3; i++) step(0, 1);     // late digests: ignored
        chk("late_digest_no_hit", n_hitp - hp0, 128'd0);
        chk("late_digest_idle", {127'b0, bus.busy}, 128'd0);
        hit_a = 2;
        load_key("abcdef");
        step(1, 0);
        chk("post_rst_suffix1", 128'(bus.header_data), 128'h0000_0061_6263_6465_6631);
        run_done(300);
        chk("post_rst_hit2", 128'(bus.hit_header), 128'h0000_0061_6263_6465_6632);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/nonce_scheduler.md
# nonce_scheduler

Search sequencer for the MD5 advent-coin miner. Takes a secret key, generates candidate block headers (key plus ascending decimal ASCII suffix 1, 2, 3, …), and issues them to the hash core over a valid/ready handshake. Holds issued headers in an in-order in-flight queue and screens each returned digest for the leading-zero target. Forwards the first matching header to the suffix extractor as `block_header_valid`/`block_header_data`.

## Interface
- `KEY_BYTES`, 8: maximum key length in characters.
- `SUFFIX_DIGITS`, 8: maximum decimal suffix digits.
- `MAX_INFLIGHT`, 64: in-flight queue depth; power of two, ≥2.
- `ZERO_NIBBLES`, 5: number of leading zero hex digits required in a digest.
- Localparam `BLOCK_HEADER_WIDTH` = 8*(KEY_BYTES+SUFFIX_DIGITS).

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle pulse; loads key and starts a search.
- `key_data` in 8*KEY_BYTES: byte k = k-th key character.
- `key_len` in $clog2(KEY_BYTES+1): key length, 1..KEY_BYTES.
- `header_valid` out 1: candidate available to hash core.
- `header_ready` in 1: hash core accepts.
- `header_data` out BLOCK_HEADER_WIDTH: candidate header.
- `digest_valid` in 1: one digest per accepted header, in issue order, arbitrary latency.
- `digest_data` in 128: MD5 digest; bit 127 is the first hex digit's MSB.
- `hit_valid` out 1: one-cycle pulse; connects to extractor `block_header_valid`.
- `hit_header` out BLOCK_HEADER_WIDTH: matching header.
- `busy` out 1: search or drain in progress.
- `overflow` out 1: suffix space exhausted without a hit; sticky until the next key or reset.

## Operation
- Header layout, with d = current suffix digit count:
  - bytes 0..d-1: ASCII suffix, least significant digit at byte 0.
  - bytes d..d+key_len-1: key reversed; key char k at byte d+key_len-1-k.
  - all higher bytes: 0x00.
  - Message string = bytes read from the highest nonzero byte down to byte 0.
- Suffix counter: SUFFIX_DIGITS BCD digits plus digit count d.
  - Starts at value 1, d=1.
  - Increments on every header handshake.
  - A carry out of the top used digit increments d (9→10, 99→100).
- States:
  - IDLE: outputs quiet. On `key_valid`, latch key, set suffix to 1, clear `overflow` → ISSUE.
  - ISSUE: `header_valid` = queue not full. A handshake pushes `header_data` into the queue and increments the suffix. If the accepted suffix was all-9 at d=SUFFIX_DIGITS, → DRAIN with exhausted flag set.
  - DRAIN: no issue. Each digest pops the queue. Entry queue empty → DONE.
  - DONE: `busy`=0. `overflow`=1 if exhausted and no hit. On `key_valid` → restart as from IDLE.
- Digest screening in any non-IDLE state:
  - `digest_valid` pops the queue head.
  - Hit iff digest_data[127 -: 4*ZERO_NIBBLES] == 0 and no hit yet this search.
  - On hit: register `hit_header` = popped header, pulse `hit_valid`, ISSUE → DRAIN.
  - Later digests are discarded, including other zero-prefix digests.
  - In-order return guarantees the reported hit is the smallest suffix.
- `key_valid` in ISSUE or DRAIN: ignored.
- `digest_valid` with queue empty: ignored; no state change.
- Push and pop in the same cycle: count unchanged. A pop frees a slot for the same cycle's issue.

## Timing
- Reset values: `header_valid`=0, `hit_valid`=0, `busy`=0, `overflow`=0, `hit_header`='0, `header_data`='0. State IDLE, queue empty.
- Reset mid-operation clears the queue and counter. Digests arriving afterward are ignored.
- `key_valid` at cycle N:
  - `busy`=1 and `header_valid`=1 at N+1, suffix "1".
  - Throughput: one header per cycle while `header_ready`=1 and the queue is not full.
- `header_data` is held stable while `header_valid`=1 and `header_ready`=0. `header_valid` is not withdrawn without a handshake, except on reset.
- Hit: `digest_valid` at cycle M → `hit_valid` pulse and `hit_header` at M+1. `hit_header` holds until the next hit or reset.
- Digit-count change (for example 9→10) happens in the same cycle as the handshake; no bubble.
- `busy` falls the cycle after the last outstanding digest is popped in DRAIN. `overflow` rises in the same cycle.

## Test plan
- Key "abcdef", len 6; stub core returns zero-prefix digest only for suffix 12:
  - 12 headers issued in order.
  - Header 10 is byte0 '0' (0x30), byte1 '1', bytes 2..7 "fedcba", byte 8 0x00.
  - `hit_header` suffix 12; extractor yields 12.
  - `busy` drops after drain.
- Backpressure: `header_ready` low 5 cycles mid-search → `header_data` constant, suffix does not advance, no duplicate or skipped values afterward.
- Queue full: core withholds digests → exactly 64 headers accepted, then `header_valid`=0. One digest → exactly one more header.
- Hits at suffixes 3 and 5 with 10 outstanding → single `hit_valid`, suffix 3. Remaining 7 digests discarded; DONE after the last one.
- SUFFIX_DIGITS=2, no hits → 99 headers (1..99), DRAIN, `overflow`=1 after the last digest, `hit_valid` never asserted. New `key_valid` clears `overflow`.
- `reset` at suffix 40 with 8 in flight → all outputs at reset values next cycle, late digests ignored. New key restarts at suffix 1.
